alu_arbiter: RTL and testbench

Shares the single combinational ALU datapath between two requesters (instruction-issue port 0 and auxiliary port 1). Each transaction is accepted over a valid/ready handshake, and operands are registered and driven onto the ALU. The ALU result is held for 1 cycle, or for `MUL_CYCLES` cycles on multiply. The result and flag are then returned over a valid/ready response channel tagged with the requester ID. The block sits between the issue logic and the ALU and is the only driver of the ALU's inputs.

---
 rtl/alu_arb_pkg.sv | 21 ++
 rtl/alu_arb_rr2.sv | 58 +++++
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared op codes, FSM state type and op legality helper for the ALU arbiter.
package alu_arb_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op != 3'b100) && (op != 3'b101);
  endfunction

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-way request arbiter. Round-robin with a last-grant pointer when
// ALU_ARB_RR_EN is defined, otherwise fixed priority to port 0.
module alu_arb_rr2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       hs_i,
  output logic [1:0] gnt_o
);

`ifdef ALU_ARB_RR_EN
  logic ptr_q;
  logic ptr_d;

  // Grant: on a tie the port that was not granted last wins
  always_comb begin
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Pointer next state: moves only when a grant is actually taken
  always_comb begin
    ptr_d = ptr_q;
    if (hs_i) begin
      ptr_d = gnt_o[1];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; resets to port 1 so port 0 wins the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{clk_i, rst_i, hs_i};

  // Grant: fixed priority, port 0 always wins
  always_comb begin
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b11:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with a valid/ready
// request side and a tagged response channel. Optional macro: ALU_ARB_RR_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [5:0]  req_op_i,
  input  logic [63:0] req_a_i,
  input  logic [63:0] req_b_i,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_flag_o,
  output logic        rsp_err_o
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_flag_q, rsp_flag_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  gnt_s;
  logic        hs_s;
  logic        sel_s;

  alu_arb_rr2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_valid_i),
    .hs_i  (hs_s),
    .gnt_o (gnt_s)
  );

  assign sel_s = gnt_s[1];

  // Ready is offered only in IDLE and is forced low while reset is held
  always_comb begin
    if ((state_q == ST_IDLE) && !rst_i) begin
      req_ready_o = gnt_s;
    end else begin
      req_ready_o = 2'b00;
    end
  end

  // Next-state and datapath capture for the IDLE/EXEC/RESP sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flag_d  = rsp_flag_q;
    rsp_err_d   = rsp_err_q;
    hs_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|(req_valid_i & gnt_s)) begin
          hs_s    = 1'b1;
          id_d    = sel_s;
          op_d    = sel_s ? req_op_i[5:3]   : req_op_i[2:0];
          a_d     = sel_s ? req_a_i[63:32]  : req_a_i[31:0];
          b_d     = sel_s ? req_b_i[63:32]  : req_b_i[31:0];
          cnt_d   = (op_d == ALU_MUL) ? MUL_LOAD : 4'd0;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (!op_is_legal(op_q)) begin
          // The ALU result is meaningless for an illegal code; report an error
          rsp_data_d  = 32'd0;
          rsp_flag_d  = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == 4'd0) begin
          rsp_data_d  = alu_data_i;
          rsp_flag_d  = alu_zero_i;
          rsp_err_d   = 1'b0;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State, operand and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      id_q        <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_flag_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flag_q  <= rsp_flag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_data1_o = a_q;
  assign alu_data2_o = b_q;
  assign alu_ctrl_o  = op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_flag_o  = rsp_flag_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, corner sequences and
// random transactions against a behavioural reference of the ALU service.
module tb_alu_arbiter;

  localparam int MULC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [5:0]  req_op = 6'd0;
  logic [63:0] req_a = 64'd0;
  logic [63:0] req_b = 64'd0;
  logic [31:0] alu_d1, alu_d2, alu_res;
  logic [2:0]  alu_ctrl;
  logic        alu_flag;
  logic        rsp_valid, rsp_id, rsp_flag, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;

  int tests = 0;
  int fails = 0;
  int last_grant = 1;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(MULC)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_ctrl_o(alu_ctrl),
    .alu_data_i(alu_res), .alu_zero_i(alu_flag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_flag_o(rsp_flag), .rsp_err_o(rsp_err)
  );

  // Reference of what a transaction must return: {flag, data}
  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] d;
    case (op)
      3'b010: begin s = {1'b0, a} + {1'b0, b}; return s; end
      3'b110: begin d = a - b; return {(a < b), d}; end
      3'b000: begin d = a & b; return {(d == 32'd0), d}; end
      3'b001: begin d = a | b; return {(d == 32'd0), d}; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return {(|p[63:32]), p[31:0]}; end
      3'b111: begin d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; return {(d == 32'd0), d}; end
      default: return 33'd0;
    endcase
  endfunction

  // Bench ALU: illegal codes produce garbage that must never reach the response
  always_comb begin
    if (alu_ctrl == 3'b100 || alu_ctrl == 3'b101) begin
      alu_res  = 32'hDEAD_BEEF;
      alu_flag = 1'b1;
    end else begin
      {alu_flag, alu_res} = ref_alu(alu_ctrl, alu_d1, alu_d2);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_port(input int port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (port == 1) begin
      req_op[5:3] = op; req_a[63:32] = a; req_b[63:32] = b;
    end else begin
      req_op[2:0] = op; req_a[31:0] = a; req_b[31:0] = b;
    end
  endtask

  // One transaction on a single port with rsp_ready held high
  task automatic run_txn(input int port, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_data, input string nm);
    logic [32:0] r;
    logic        exp_err;
    int          exp_lat, n, lat;
    r = ref_alu(op, a, b);
    exp_err = (op == 3'b100 || op == 3'b101);
    exp_lat = (op == 3'b011) ? 1 + MULC : 2;
    @(negedge clk);
    set_port(port, op, a, b);
    req_valid = (port == 1) ? 2'b10 : 2'b01;
    #1;
    n = 0;
    while (req_ready != req_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " ready"}, {62'd0, req_ready}, {62'd0, req_valid});
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk({nm, " ctrl@1"}, {61'd0, alu_ctrl}, {61'd0, op});
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      chk({nm, " alu_in"}, {alu_d1, alu_d2}, {a, b});
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " data"}, {32'd0, rsp_data}, {32'd0, exp_data});
    chk({nm, " flag/err/id"}, {61'd0, rsp_flag, rsp_err, rsp_id},
        {61'd0, (exp_err ? 1'b0 : r[32]), exp_err, port[0]});
    @(negedge clk);
    chk({nm, " rsp 1cyc"}, {63'd0, rsp_valid}, 64'd0);
    last_grant = port;
  endtask

  typedef struct {
    int          port;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          grants[4];
    int          exp_g, g;
    logic [31:0] snap_d;
    logic [2:0]  snap_f;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rport, seen;
    logic [32:0] rr;

    vecs[0] = '{0, 3'b010, 32'd5,       32'd7,       32'd12};
    vecs[1] = '{1, 3'b011, 32'd3,       32'd4,       32'd12};
    vecs[2] = '{0, 3'b101, 32'd1,       32'd2,       32'd0};
    vecs[3] = '{0, 3'b000, 32'hF0F0,    32'hFF00,    32'hF000};
    vecs[4] = '{1, 3'b001, 32'h0000_00F0, 32'h0F00_0000, 32'h0F00_00F0};
    vecs[5] = '{0, 3'b110, 32'd9,       32'd4,       32'd5};
    vecs[6] = '{1, 3'b111, 32'hFFFF_FFFD, 32'd9,     32'd1};
    vecs[7] = '{1, 3'b100, 32'd8,       32'd8,       32'd0};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset outs", {rsp_valid, rsp_id, rsp_flag, rsp_err, rsp_data, 28'd0},
        64'd0);
    chk("reset alu", {alu_d1, alu_d2}, 64'd0);
    chk("reset ctrl/ready", {59'd0, alu_ctrl, req_ready}, 64'd0);
    rst = 1'b0;
    last_grant = 1;

    foreach (vecs[i])
      run_txn(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_data, $sformatf("vec%0d", i));

    // both ports request continuously
    @(negedge clk);
    set_port(0, 3'b010, 32'd1, 32'd1);
    set_port(1, 3'b010, 32'd2, 32'd2);
    req_valid = 2'b11;
    g = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        grants[g] = int'(req_ready[1]);
        g++;
      end
      if (g < 4) @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk("grant count", 64'(g), 64'd4);
    exp_g = last_grant;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = 1 - exp_g;
`else
      exp_g = 0;
`endif
      chk($sformatf("grant%0d", k), 64'(grants[k]), 64'(exp_g));
    end
    last_grant = grants[3];
    repeat (8) @(negedge clk);

    // backpressure: response held 10 cycles, port 1 waits
    rsp_ready = 1'b0;
    set_port(0, 3'b001, 32'h00A0, 32'h0005);
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("bp valid@2", {63'd0, rsp_valid}, 64'd1);
    snap_d = rsp_data;
    snap_f = {rsp_id, rsp_flag, rsp_err};
    chk("bp data", {32'd0, snap_d}, 64'h00A5);
    set_port(1, 3'b010, 32'd3, 32'd3);
    req_valid = 2'b10;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk); #1;
      chk($sformatf("bp hold%0d", c), {27'd0, rsp_valid, snap_f, req_ready, rsp_data},
          {27'd0, 1'b1, 3'b000, 2'b00, snap_d});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    chk("bp valid@11", {63'd0, rsp_valid}, 64'd1);
    @(negedge clk); #1;
    chk("bp idle@12", {62'd0, rsp_valid, req_ready}, {62'd0, 1'b0, 2'b10});
    req_valid = 2'b00;
    last_grant = 0;
    repeat (3) @(negedge clk);
    chk("drop no-op", {63'd0, rsp_valid}, 64'd0);
    run_txn(1, 3'b010, 32'd6, 32'd1, 32'd7, "after-drop");

    // reset during a mul
    @(negedge clk);
    set_port(1, 3'b011, 32'd3, 32'd4);
    req_valid = 2'b10;
    @(posedge clk);
    @(negedge clk);
    set_port(0, 3'b010, 32'd1, 32'd1);
    req_valid = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst async rsp", {rsp_valid, rsp_id, rsp_flag, rsp_err, rsp_data, 28'd0}, 64'd0);
    chk("rst async alu", {alu_d1, alu_d2}, 64'd0);
    chk("rst async ctrl/ready", {59'd0, alu_ctrl, req_ready}, 64'd0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    last_grant = 1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst no rsp", 64'(seen), 64'd0);
    run_txn(0, 3'b110, 32'd9, 32'd4, 32'd5, "post-rst sub");

    // random transactions
    for (int t = 0; t < 30; t++) begin
      rport = int'($urandom_range(1, 0));
      rop = 3'($urandom_range(7, 0));
      ra = $urandom;
      rb = (t % 3 == 0) ? 32'($urandom_range(20, 0)) : $urandom;
      rr = ref_alu(rop, ra, rb);
      run_txn(rport, rop, ra, rb, rr[31:0], $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
